// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - shared instruction/data memory handshake between sequencer and memory
interface multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multi-cycle Moore sequencer with traps; perf counters under MULTICYCLE_PERF_CNT_EN
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  multicycle_control_if.master mem,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Last wait count that may still complete; one more idle cycle past it traps.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [6:0] op_q;
  logic [7:0] wait_cnt;
  logic [1:0] cause_q;
  logic [1:0] next_cause;
  logic       retire;
  logic       wait_last;

  assign wait_last  = (wait_cnt == WAIT_LAST);
  assign trap_cause = cause_q;

  // State, latched opcode, trap cause and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 7'd0;
      wait_cnt <= 8'd0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= next_cause;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
      // Any state change restarts the count, which covers entry to FETCH and MEM.
      if (next_state != state) begin
        wait_cnt <= 8'd0;
      end else if ((state == S_FETCH || state == S_MEM) && !mem.mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Next-state and Moore control decode; only FETCH completion and branch redirect look at inputs.
  always_comb begin
    next_state    = state;
    next_cause    = cause_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    mem.iord      = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    busy          = 1'b0;
    trap          = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end

      S_FETCH: begin
        busy         = 1'b1;
        mem.mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_last) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR: next_state = S_EXEC;
          default: begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_R: begin
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src    = 1'b1;
            alu_op     = 2'b10;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src    = 1'b1;
            next_state = S_MEM;
          end
          OP_BR: begin
            alu_op     = 2'b01;
            pc_write   = zero;
            pc_src     = zero;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          default: begin
            // op_q only ever holds a legal opcode here; kept safe regardless.
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEM: begin
        busy     = 1'b1;
        mem.iord = 1'b1;
        if (op_q == OP_STORE) begin
          mem.mem_write = 1'b1;
        end else begin
          mem.mem_read = 1'b1;
        end
        if (mem.mem_ready) begin
          if (op_q == OP_STORE) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_last) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        busy       = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] cycle_q;

  // Retired-instruction and busy-cycle counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      cycle_q  <= '0;
    end else begin
      if (retire) begin
        retire_q <= retire_q + 1'b1;
      end
      if (busy) begin
        cycle_q <= cycle_q + 1'b1;
      end
    end
  end

  assign retire_cnt = retire_q;
  assign cycle_cnt  = cycle_q;
`else
  // Without counters the retire strobe has no consumer.
  logic retire_unused;
  assign retire_unused = retire;
  assign retire_cnt    = '0;
  assign cycle_cnt     = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0000111;

  // {pc_write, pc_src, ir_write, iord, alu_src, alu_op[1:0], mem_read, mem_write,
  //  mem_to_reg, reg_write, busy, trap, trap_cause[1:0]}
  localparam logic [14:0] E_IDLE       = 15'b0_0_0_0_0_00_0_0_0_0_0_0_00;
  localparam logic [14:0] E_FETCH_WAIT = 15'b0_0_0_0_0_00_1_0_0_0_1_0_00;
  localparam logic [14:0] E_FETCH_DONE = 15'b1_0_1_0_0_00_1_0_0_0_1_0_00;
  localparam logic [14:0] E_DECODE     = 15'b0_0_0_0_0_00_0_0_0_0_1_0_00;
  localparam logic [14:0] E_EXEC_R     = 15'b0_0_0_0_0_10_0_0_0_0_1_0_00;
  localparam logic [14:0] E_EXEC_I     = 15'b0_0_0_0_1_10_0_0_0_0_1_0_00;
  localparam logic [14:0] E_EXEC_LS    = 15'b0_0_0_0_1_00_0_0_0_0_1_0_00;
  localparam logic [14:0] E_EXEC_BT    = 15'b1_1_0_0_0_01_0_0_0_0_1_0_00;
  localparam logic [14:0] E_EXEC_BN    = 15'b0_0_0_0_0_01_0_0_0_0_1_0_00;
  localparam logic [14:0] E_MEM_LD     = 15'b0_0_0_1_0_00_1_0_0_0_1_0_00;
  localparam logic [14:0] E_MEM_ST     = 15'b0_0_0_1_0_00_0_1_0_0_1_0_00;
  localparam logic [14:0] E_WB_LD      = 15'b0_0_0_0_0_00_0_0_1_1_1_0_00;
  localparam logic [14:0] E_WB_ALU     = 15'b0_0_0_0_0_00_0_0_0_1_1_0_00;
  localparam logic [14:0] E_TRAP_ILL   = 15'b0_0_0_0_0_00_0_0_0_0_0_1_01;
  localparam logic [14:0] E_TRAP_TO    = 15'b0_0_0_0_0_00_0_0_0_0_0_1_10;

  typedef struct packed {
    logic [14:0] ctrl;
    logic [15:0] ret;
    logic [15:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode;
  logic        zero;
  logic        pc_write, pc_src, ir_write, alu_src, mem_to_reg, reg_write, busy, trap;
  logic [1:0]  alu_op, trap_cause;
  logic [15:0] retire_cnt, cycle_cnt;

  multicycle_control_if bus();

  multicycle_control #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (bus),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .busy       (busy),
    .trap       (trap),
    .trap_cause (trap_cause),
    .retire_cnt (retire_cnt),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_ret = 0;
  int   exp_cyc = 0;

  function automatic logic [14:0] ctrl_now();
    return {pc_write, pc_src, ir_write, bus.iord, alu_src, alu_op, bus.mem_read,
            bus.mem_write, mem_to_reg, reg_write, busy, trap, trap_cause};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic rdy, input logic z, input logic [6:0] op,
                      input logic [14:0] ev, input bit ret);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mem_ready = rdy;
    zero          = z;
    opcode        = op;
    e.ctrl = ev;
`ifdef MULTICYCLE_PERF_CNT_EN
    e.ret = 16'(exp_ret);
    e.cyc = 16'(exp_cyc);
`else
    e.ret = 16'd0;
    e.cyc = 16'd0;
`endif
    q.push_back(e);
    if (ev[3]) exp_cyc++;
    if (ret) exp_ret++;
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 7'd0;
    exp_ret = 0;
    exp_cyc = 0;
    e = '{ctrl: E_IDLE, ret: 16'd0, cyc: 16'd0};
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back(e);
  endtask

  task automatic front(input logic [6:0] op);
    step(1'b1, 1'b0, op, E_FETCH_DONE, 1'b0);
    step(1'b1, 1'b0, op, E_DECODE, 1'b0);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctrl", 32'(ctrl_now()), 32'(e.ctrl));
      chk("retire_cnt", 32'(retire_cnt), 32'(e.ret));
      chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
      chk("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
    end
  end

  initial begin
    bus.mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 7'd0;
    do_reset();

    front(OP_R);
    step(1'b1, 1'b0, OP_R, E_EXEC_R, 1'b0);
    step(1'b1, 1'b0, OP_R, E_WB_ALU, 1'b1);

    front(OP_I);
    step(1'b1, 1'b0, OP_I, E_EXEC_I, 1'b0);
    step(1'b1, 1'b0, OP_I, E_WB_ALU, 1'b1);

    front(OP_LD);
    step(1'b1, 1'b0, OP_LD, E_EXEC_LS, 1'b0);
    repeat (3) step(1'b0, 1'b0, OP_LD, E_MEM_LD, 1'b0);
    step(1'b1, 1'b0, OP_LD, E_MEM_LD, 1'b0);
    step(1'b1, 1'b0, OP_LD, E_WB_LD, 1'b1);

    front(OP_ST);
    step(1'b1, 1'b0, OP_ST, E_EXEC_LS, 1'b0);
    step(1'b1, 1'b0, OP_ST, E_MEM_ST, 1'b1);

    front(OP_BR);
    step(1'b1, 1'b1, OP_BR, E_EXEC_BT, 1'b1);
    front(OP_BR);
    step(1'b1, 1'b0, OP_BR, E_EXEC_BN, 1'b1);

    repeat (14) step(1'b0, 1'b0, OP_R, E_FETCH_WAIT, 1'b0);
    front(OP_R);
    step(1'b1, 1'b0, OP_R, E_EXEC_R, 1'b0);
    step(1'b1, 1'b0, OP_R, E_WB_ALU, 1'b1);

    repeat (15) step(1'b0, 1'b0, OP_R, E_FETCH_WAIT, 1'b0);
    repeat (3) step(1'b1, 1'b0, OP_R, E_TRAP_TO, 1'b0);

    do_reset();
    front(OP_BAD);
    repeat (20) step(1'b1, 1'b0, OP_R, E_TRAP_ILL, 1'b0);

    do_reset();
    front(OP_LD);
    step(1'b1, 1'b0, OP_LD, E_EXEC_LS, 1'b0);
    repeat (15) step(1'b0, 1'b0, OP_LD, E_MEM_LD, 1'b0);
    step(1'b1, 1'b0, OP_LD, E_TRAP_TO, 1'b0);

    do_reset();
    front(OP_ST);
    step(1'b1, 1'b0, OP_ST, E_EXEC_LS, 1'b0);
    repeat (2) step(1'b0, 1'b0, OP_ST, E_MEM_ST, 1'b0);
    @(posedge clk);
    #1;
    chk("st_mem_write_before_rst", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl_now()), 32'(E_IDLE));
    chk("async_rst_retire", 32'(retire_cnt), 32'd0);
    chk("async_rst_cycle", 32'(cycle_cnt), 32'd0);

    do_reset();
    front(OP_R);
    step(1'b1, 1'b0, OP_R, E_EXEC_R, 1'b0);
    step(1'b1, 1'b0, OP_R, E_WB_ALU, 1'b1);
    step(1'b1, 1'b0, OP_R, E_FETCH_DONE, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle control decode with a Moore FSM that walks each instruction through the FETCH/DECODE/EXEC/MEM/WB steps, waiting on a shared instruction/data memory handshake. It drives the same control set as the single-cycle unit, plus PC/IR write enables and memory address select. It also traps on illegal opcodes and on memory timeouts.

Parameters:
TIMEOUT, 15, maximum cycles waiting for mem_ready in any memory state before a bus-error trap (1..255).
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
opcode  input  7  instr[6:0] from the IR; valid from DECODE onward.
zero  input  1  ALU zero flag.
mem_ready  input  1  memory completes the current read/write this cycle.
pc_write  output  1  PC register load enable.
pc_src  output  1  0 = PC+4, 1 = branch target.
ir_write  output  1  IR load enable.
iord  output  1  memory address select: 0 = PC, 1 = ALU result.
alu_src  output  1  ALU B select: 0 = rs2, 1 = immediate.
alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct decode.
mem_read  output  1  memory read strobe.
mem_write  output  1  memory write strobe.
mem_to_reg  output  1  writeback select: 1 = memory data.
reg_write  output  1  register-file write enable.
busy  output  1  high in every state except IDLE and TRAP.
trap  output  1  sticky; set on an illegal opcode or memory timeout.
trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
retire_cnt  output  CNT_W  instructions retired.
cycle_cnt  output  CNT_W  cycles spent with busy high.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, op_q = 0, wait counter = 0, counters = 0.
  - All control outputs 0; trap = 0, trap_cause = 00.
- Outputs are decoded from state and op_q only (Moore); no output depends combinationally on mem_ready, except where noted for pc_write and ir_write.
- IDLE: all outputs 0 -> FETCH on the next clock.
- FETCH:
  - mem_read = 1, iord = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0 in that same cycle (these two depend on mem_ready); -> DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch op_q <= opcode.
  - Legal opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch) -> EXEC.
  - Any other opcode -> TRAP with cause 01.
- EXEC:
  - R: alu_src = 0, alu_op = 10 -> WB.
  - I-ALU: alu_src = 1, alu_op = 10 -> WB.
  - Load/store: alu_src = 1, alu_op = 00 -> MEM.
  - Branch: alu_src = 0, alu_op = 01; if zero = 1, pc_write = 1 and pc_src = 1. Retire; -> FETCH.
- MEM:
  - Load: mem_read = 1, iord = 1; on mem_ready -> WB.
  - Store: mem_write = 1, iord = 1; on mem_ready retire and -> FETCH.
- WB: reg_write = 1, mem_to_reg = 1 for a load, else 0. Retire; -> FETCH.
- TRAP:
  - All control outputs 0, busy = 0, trap = 1.
  - trap_cause holds its value; the state is left only by reset.
- Latency with mem_ready high immediately:
  - R / I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_ready = 0 in those states.
  - Reaching TIMEOUT -> TRAP with cause 10.
  - mem_ready = 1 in the same cycle the counter reaches TIMEOUT counts as completion; no trap.
- Counters:
  - retire_cnt increments by 1 on each retire cycle.
  - cycle_cnt increments every cycle busy = 1.
  - Both wrap modulo 2^CNT_W.
- mem_read and mem_write are never high in the same cycle.

Optional Feature:
MULTICYCLE_PERF_CNT_EN:
- Defined: retire_cnt and cycle_cnt are implemented as specified.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. FSM behaviour is unchanged.

Test Plan:
- Reset then opcode 0110011, mem_ready = 1 -> states IDLE, FETCH, DECODE, EXEC, WB; reg_write = 1 in WB with mem_to_reg = 0, alu_op = 10; retire_cnt = 1.
- opcode 0000011, mem_ready low 3 cycles in MEM -> mem_read = 1, iord = 1 held 4 cycles; WB with mem_to_reg = 1; total 8 cycles FETCH-to-FETCH.
- opcode 1100011 with zero = 1, then zero = 0 -> EXEC has pc_write = 1, pc_src = 1 in the first case; pc_write = 0 in the second; each back to FETCH after 3 cycles.
- opcode 0000111 -> TRAP the cycle after DECODE; trap = 1, trap_cause = 01, busy = 0; held for 20 cycles until rst_n low.
- mem_ready held 0 in FETCH -> trap_cause = 10 after 15 wait cycles; repeat with mem_ready = 1 on cycle 15 -> no trap, ir_write = 1.
- rst_n pulsed low mid-MEM of a store -> mem_write drops immediately (asynchronous), all outputs 0, counters 0; restart from IDLE.
